fft_magnitude_writer: RTL and testbench
=======================================

Name: fft_magnitude_writer

Overview:
Streaming writer that fills the spectrum RAM read by the harmonic product spectrum block.
- Accepts complex FFT bins (AXI-stream style) from the FFT IP.
- Computes |X[k]|^2 = re^2 + im^2 and writes it to RAM address k.
- Pulses frame_done, which drives the HPS fft_last input.
- Holds off the next frame until the reader releases the RAM.

Parameters:
K_WIDTH, 12, log2 of FFT length N (4096 bins)
SAMPLE_WIDTH, 16, signed width of the re and im components
DATA_WIDTH, 34, unsigned magnitude-squared width; must be >= 2*SAMPLE_WIDTH+1

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
s_tdata  in  2*SAMPLE_WIDTH  bin: im in the upper half, re in the lower half, both two's complement
s_tvalid  in  1  bin valid
s_tlast  in  1  last bin of the frame
s_tready  out  1  writer can accept a bin
reader_release  in  1  one-cycle pulse from the reader: RAM consumed, next frame allowed
ram_wr_addr  out  K_WIDTH  write address (= k)
ram_wr_data  out  DATA_WIDTH  re^2 + im^2, zero-extended
ram_wr_en  out  1  write strobe
frame_done  out  1  one-cycle pulse after the last RAM write of the frame
frame_error  out  1  tlast/length mismatch in the latest frame; sticky until the next frame's first accept

Behaviour:
- Reset values: s_tready=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, frame_done=0, frame_error=0, state=IDLE, k=0, pipeline valids cleared.
- Reset mid-frame discards partial data. No frame_done is emitted. RAM contents are not cleared.
- Beats are accepted on s_tvalid && s_tready. k is the accept counter.
- Pipeline:
  - Stage 1: register re*re and im*im (each 2*SAMPLE_WIDTH unsigned), plus k and a last flag.
  - Stage 2: register the sum, zero-extended to DATA_WIDTH.
  - The write is presented on the stage-2 outputs: ram_wr_en=1 exactly 2 cycles after accept.
  - Full throughput: one bin per cycle.
- Arithmetic: (-2^(SW-1))^2 * 2 = 2^(2SW-1) fits in 2SW+1 bits. No saturation.
- End of frame: the first beat with s_tlast=1 OR k==N-1, whichever comes first.
  - frame_error=1 if tlast arrives with k<N-1, or if k==N-1 arrives without tlast.
  - Beats after a forced end wait in HOLD; the source stalls on s_tready=0.
- States:
  - IDLE: s_tready=1. First accept clears frame_error and k, goes to FILL. If that beat ends the frame (N=1 or early tlast), go straight to DRAIN.
  - FILL: s_tready=1, k increments per accept. End-of-frame accept goes to DRAIN.
  - DRAIN: s_tready=0. Wait until the stage-2 last write has issued, then go to DONE.
  - DONE: frame_done=1 for one cycle. Unconditionally go to HOLD.
  - HOLD: s_tready=0. reader_release goes to IDLE; s_tready=1 on the next cycle.
- reader_release outside HOLD is ignored. A release in the same cycle as DONE is also ignored; the reader must release after frame_done.
- frame_done is asserted the cycle after the final ram_wr_en, so the reader never sees a partially written frame.
- k wraps naturally at 2^K_WIDTH. Wrap is never observed because the frame ends at N-1.

Optional Feature:
FFT_MAG_HALF_SPECTRUM_EN
- Defined: ram_wr_en is suppressed for k >= N/2; only bins 0..N/2-1 are written (real input, symmetric spectrum). Frame length and error rules are unchanged, and frame_done timing is unchanged.
- Undefined: all N bins are written.

Decomposition:
- Shared package: bin-unpack constants (RE_LSB, IM_LSB); the state encoding localparams IDLE/FILL/DRAIN/DONE/HOLD; MAG_WIDTH function returning 2*SAMPLE_WIDTH+1. The same package is used by the HPS for DATA_WIDTH checks.
- Natural sub-module: complex_mag_sq — the 2-stage pipelined re^2+im^2 with valid/last/addr sideband.

Test Plan:
- N=8 (K_WIDTH=3), bins re=k, im=-k, tlast on k=7, tvalid continuous:
  - writes addr 0..7, data 2k^2 (0, 2, 8, ..., 98), each 2 cycles after accept;
  - frame_done one cycle after the addr-7 write; frame_error=0.
- Extreme values: re=-32768, im=-32768 -> ram_wr_data=0x080000000 (2^31). re=32767, im=0 -> 0x3FFF0001.
- Early tlast at k=4 -> 5 writes, frame_done pulses, frame_error=1. The next frame's first accept clears frame_error.
- Missing tlast through k=7 -> frame ends after 8 writes with frame_error=1. s_tready=0 until reader_release, and the 9th beat is held by the source.
- Backpressure and holdoff:
  - reader_release withheld 20 cycles -> s_tready stays 0 for 20 cycles, no writes; release -> s_tready=1 the next cycle.
  - Random tvalid gaps give the same RAM contents as the continuous case.
- Reset asserted at k=3 -> all outputs return to reset values on the next edge, no frame_done. A new full frame then completes normally.
- Feature build with FFT_MAG_HALF_SPECTRUM_EN and N=8 -> writes only addr 0..3, frame_done at the same cycle as the non-feature run.

Source files
------------

// File: rtl/fft_magnitude_writer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fft_magnitude_writer_pkg
// Brief   : Shared bin layout, magnitude width helper and writer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package fft_magnitude_writer_pkg;

    // Real part sits in the low half of a bin word, imaginary part above it.
    localparam int RE_LSB = 0;

    function automatic int im_lsb(input int sample_width);
        return sample_width;
    endfunction

    // Width of re^2 + im^2 without overflow; the HPS reader checks DATA_WIDTH against this.
    function automatic int MAG_WIDTH(input int sample_width);
        return 2 * sample_width + 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_magnitude_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fft_magnitude_writer_if
// Brief   : AXI-stream style complex-bin channel from the FFT IP to the writer.
// Revision: 1.0 - initial release
// ============================================================================
interface fft_magnitude_writer_if #(
    parameter int SAMPLE_WIDTH = 16
) ();

    logic [2*SAMPLE_WIDTH-1:0] s_tdata;
    logic                      s_tvalid;
    logic                      s_tlast;
    logic                      s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );

endinterface
`default_nettype wire

// File: rtl/fft_magnitude_writer_complex_mag_sq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : complex_mag_sq
// Brief   : Two-stage pipelined re^2 + im^2 with valid/last/address sideband.
// Revision: 1.0 - initial release
// ============================================================================
module complex_mag_sq
    import fft_magnitude_writer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 34
) (
    input  wire logic                           clock,
    input  wire logic                           reset_n,
    input  wire logic                           in_valid,
    input  wire logic                           in_last,
    input  wire logic signed [SAMPLE_WIDTH-1:0] in_re,
    input  wire logic signed [SAMPLE_WIDTH-1:0] in_im,
    input  wire logic        [ADDR_WIDTH-1:0]   in_addr,
    output logic                                out_valid,
    output logic                                out_last,
    output logic             [ADDR_WIDTH-1:0]   out_addr,
    output logic             [DATA_WIDTH-1:0]   out_data
);

    localparam int SQ_WIDTH  = 2 * SAMPLE_WIDTH;
    localparam int M_WIDTH   = MAG_WIDTH(SAMPLE_WIDTH);

    logic signed [SQ_WIDTH-1:0] re_ext;
    logic signed [SQ_WIDTH-1:0] im_ext;
    logic signed [SQ_WIDTH-1:0] re_sq;
    logic signed [SQ_WIDTH-1:0] im_sq;
    logic        [M_WIDTH-1:0]  mag_sum;
    logic        [DATA_WIDTH-1:0] mag_ext;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_last_q,  s1_last_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q,  s1_addr_d;
    logic [SQ_WIDTH-1:0]   s1_re_sq_q, s1_re_sq_d;
    logic [SQ_WIDTH-1:0]   s1_im_sq_q, s1_im_sq_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_last_q,  s2_last_d;
    logic [ADDR_WIDTH-1:0] s2_addr_q,  s2_addr_d;
    logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;

    // Squares are never negative, so the signed products are stored as unsigned.
    assign re_ext  = SQ_WIDTH'(in_re);
    assign im_ext  = SQ_WIDTH'(in_im);
    assign re_sq   = re_ext * re_ext;
    assign im_sq   = im_ext * im_ext;
    assign mag_sum = {1'b0, s1_re_sq_q} + {1'b0, s1_im_sq_q};

    generate
        if (DATA_WIDTH > M_WIDTH) begin : g_zext
            assign mag_ext = {{(DATA_WIDTH - M_WIDTH){1'b0}}, mag_sum};
        end else begin : g_fit
            assign mag_ext = mag_sum[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        s1_valid_d = in_valid;
        s1_last_d  = in_valid && in_last;
        s1_addr_d  = in_addr;
        s1_re_sq_d = re_sq;
        s1_im_sq_d = im_sq;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_addr_d  = s1_addr_q;
        s2_data_d  = mag_ext;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_addr_q  <= '0;
            s1_re_sq_q <= '0;
            s1_im_sq_q <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_addr_q  <= s1_addr_d;
            s1_re_sq_q <= s1_re_sq_d;
            s1_im_sq_q <= s1_im_sq_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_last  = s2_last_q;
    assign out_addr  = s2_addr_q;
    assign out_data  = s2_data_q;

endmodule
`default_nettype wire

// File: rtl/fft_magnitude_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fft_magnitude_writer
// Brief   : Writes |X[k]|^2 of each FFT frame into the HPS spectrum RAM.
//           Define FFT_MAG_HALF_SPECTRUM_EN to write only bins 0..N/2-1.
// Revision: 1.0 - initial release
// ============================================================================
module fft_magnitude_writer
    import fft_magnitude_writer_pkg::*;
#(
    parameter int K_WIDTH      = 12,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DATA_WIDTH   = 34
) (
    input  wire logic                   clock,
    input  wire logic                   reset_n,
    fft_magnitude_writer_if.slave       bin,
    input  wire logic                   reader_release,
    output logic [K_WIDTH-1:0]          ram_wr_addr,
    output logic [DATA_WIDTH-1:0]       ram_wr_data,
    output logic                        ram_wr_en,
    output logic                        frame_done,
    output logic                        frame_error
);

    // N is a power of two, so N-1 is all ones.
    localparam logic [K_WIDTH-1:0] LAST_K = '1;

    fsm_state_e          state_q, state_d;
    logic [K_WIDTH-1:0]  k_q, k_d;
    logic                tready_q, tready_d;
    logic                frame_error_q, frame_error_d;

    logic signed [SAMPLE_WIDTH-1:0] bin_re;
    logic signed [SAMPLE_WIDTH-1:0] bin_im;
    logic [K_WIDTH-1:0]  beat_idx;
    logic                accept;
    logic                is_last_k;
    logic                frame_end;
    logic                beat_err;

    logic                pipe_valid;
    logic                pipe_last;
    logic [K_WIDTH-1:0]  pipe_addr;
    logic [DATA_WIDTH-1:0] pipe_data;

    assign bin_re    = bin.s_tdata[RE_LSB +: SAMPLE_WIDTH];
    assign bin_im    = bin.s_tdata[im_lsb(SAMPLE_WIDTH) +: SAMPLE_WIDTH];
    assign accept    = bin.s_tvalid && tready_q;
    assign beat_idx  = (state_q == IDLE) ? '0 : k_q;
    assign is_last_k = (beat_idx == LAST_K);
    assign frame_end = accept && (bin.s_tlast || is_last_k);
    // Mismatch only matters on the beat that ends the frame; elsewhere both terms are 0.
    assign beat_err  = bin.s_tlast ^ is_last_k;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        frame_error_d = frame_error_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    k_d           = beat_idx + K_WIDTH'(1);
                    frame_error_d = beat_err;
                    state_d       = frame_end ? DRAIN : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    k_d           = k_q + K_WIDTH'(1);
                    frame_error_d = frame_error_q | beat_err;
                    if (frame_end) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_valid && pipe_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (reader_release) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tready_d = (state_d == IDLE) || (state_d == FILL);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            tready_q      <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            tready_q      <= tready_d;
            frame_error_q <= frame_error_d;
        end
    end

    complex_mag_sq #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ADDR_WIDTH   (K_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_mag_sq (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (accept),
        .in_last   (frame_end),
        .in_re     (bin_re),
        .in_im     (bin_im),
        .in_addr   (beat_idx),
        .out_valid (pipe_valid),
        .out_last  (pipe_last),
        .out_addr  (pipe_addr),
        .out_data  (pipe_data)
    );

`ifdef FFT_MAG_HALF_SPECTRUM_EN
    // Upper half mirrors the lower half for real input; the frame still drains through it.
    assign ram_wr_en = pipe_valid && !pipe_addr[K_WIDTH-1];
`else
    assign ram_wr_en = pipe_valid;
`endif

    assign ram_wr_addr  = pipe_addr;
    assign ram_wr_data  = pipe_data;
    assign frame_done   = (state_q == DONE);
    assign frame_error  = frame_error_q;
    assign bin.s_tready = tready_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_magnitude_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fft_magnitude_writer
// Brief   : Random-stimulus bench for the writer (N=8) against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_magnitude_writer;

    localparam int K_WIDTH      = 3;
    localparam int SAMPLE_WIDTH = 16;
    localparam int DATA_WIDTH   = 34;
    localparam int N            = 8;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  reader_release = 1'b0;
    logic [K_WIDTH-1:0]    ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_wr_en;
    logic                  frame_done;
    logic                  frame_error;

    fft_magnitude_writer_if #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) bin_if ();

    fft_magnitude_writer #(
        .K_WIDTH      (K_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bin            (bin_if.slave),
        .reader_release (reader_release),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .ram_wr_en      (ram_wr_en),
        .frame_done     (frame_done),
        .frame_error    (frame_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = in reset / first cycle after, 1 = accepting bins, 2 = frame closed
    typedef struct {
        int     addr;
        longint data;
        int     due;
    } wr_t;

    wr_t    wq[$];
    wr_t    w;
    int     phase = 0;
    int     model_k = 0;
    bit     err_exp = 1'b0;
    bit     done_pending = 1'b0;
    int     done_cyc = -10;
    bit     at_end_k;
    bit     berr;
    logic signed [15:0] re16, im16;
    longint re_l, im_l;

    always @(negedge clock) begin
        check_eq("s_tready", bin_if.s_tready, longint'(phase == 1));
        check_eq("frame_error", frame_error, err_exp);
        if (frame_done || (done_pending && cyc == done_cyc))
            check_eq("frame_done", frame_done, longint'(done_pending && cyc == done_cyc));
        if (done_pending && cyc >= done_cyc) done_pending = 1'b0;

        if (wq.size() > 0 && wq[0].due == cyc) begin
            w = wq.pop_front();
            check_eq("wr_en", ram_wr_en, 1);
            if (ram_wr_en) begin
                check_eq("wr_addr", ram_wr_addr, w.addr);
                check_eq("wr_data", ram_wr_data, w.data);
            end
        end else begin
            check_eq("wr_en_idle", ram_wr_en, 0);
        end

        if (!reset_n) begin
            phase        = 0;
            model_k      = 0;
            err_exp      = 1'b0;
            done_pending = 1'b0;
            wq.delete();
        end else begin
            case (phase)
                0: phase = 1;
                1: if (bin_if.s_tvalid) begin
                    re16 = bin_if.s_tdata[15:0];
                    im16 = bin_if.s_tdata[31:16];
                    re_l = re16;
                    im_l = im16;
                    w.addr = model_k;
                    w.data = re_l * re_l + im_l * im_l;
                    w.due  = cyc + 2;
`ifdef FFT_MAG_HALF_SPECTRUM_EN
                    if (model_k < N / 2) wq.push_back(w);
`else
                    wq.push_back(w);
`endif
                    at_end_k = (model_k == N - 1);
                    berr     = bin_if.s_tlast != at_end_k;
                    err_exp  = (model_k == 0) ? berr : (err_exp | berr);
                    if (bin_if.s_tlast || at_end_k) begin
                        phase        = 2;
                        model_k      = 0;
                        done_cyc     = cyc + 3;
                        done_pending = 1'b1;
                    end else begin
                        model_k++;
                    end
                end
                default: if (reader_release && cyc >= done_cyc + 1) phase = 1;
            endcase
        end
    end

    // ---------------- reader: releases the RAM after frame_done ----------------
    int rel_delay   = 2;
    bit rel_in_done = 1'b1;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (frame_done) begin
                if (rel_in_done) reader_release = 1'b1;
                @(posedge clock);
                #1;
                reader_release = 1'b0;
                repeat (rel_delay) begin
                    @(posedge clock);
                    #1;
                end
                reader_release = 1'b1;
                @(posedge clock);
                #1;
                reader_release = 1'b0;
            end
        end
    end

    // ---------------- source ----------------
    task automatic send_beat(input int re, input int im, input bit last, input int max_gap);
        int gap;
        int waited;
        bit taken;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        if (gap > 0) begin
            bin_if.s_tvalid = 1'b0;
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
        bin_if.s_tvalid = 1'b1;
        bin_if.s_tdata  = {im[15:0], re[15:0]};
        bin_if.s_tlast  = last;
        waited = 0;
        forever begin
            @(negedge clock);
            taken = bin_if.s_tready && reset_n;
            @(posedge clock);
            #1;
            if (taken) break;
            waited++;
            if (waited > 100) begin
                check_eq("accept_timeout", bin_if.s_tready, 1);
                break;
            end
        end
    endtask

    task automatic bus_idle();
        bin_if.s_tvalid = 1'b0;
        bin_if.s_tlast  = 1'b0;
    endtask

    task automatic ramp_frame(input int max_gap);
        for (int k = 0; k < N; k++) send_beat(k, -k, k == N - 1, max_gap);
        bus_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_en"}, ram_wr_en, 0);
        check_eq({tag, "_wr_addr"}, ram_wr_addr, 0);
        check_eq({tag, "_wr_data"}, ram_wr_data, 0);
        check_eq({tag, "_done"}, frame_done, 0);
        check_eq({tag, "_error"}, frame_error, 0);
        check_eq({tag, "_tready"}, bin_if.s_tready, 0);
    endtask

    initial begin
        int end_pos;
        int nbeats;
        int re;
        int im;
        bin_if.s_tvalid = 1'b0;
        bin_if.s_tlast  = 1'b0;
        bin_if.s_tdata  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("por");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // re=k, im=-k, continuous, then the same frame with random gaps
        ramp_frame(0);
        ramp_frame(3);

        // extreme component values
        send_beat(-32768, -32768, 1'b0, 0);
        send_beat(32767, 0, 1'b0, 0);
        send_beat(-32768, 32767, 1'b0, 0);
        send_beat(0, -32768, 1'b0, 0);
        send_beat(1, -1, 1'b0, 0);
        send_beat(-1, 0, 1'b0, 0);
        send_beat(32767, 32767, 1'b0, 0);
        send_beat(0, 0, 1'b1, 0);
        bus_idle();

        // early tlast at k=4, then a normal frame clears the error
        for (int k = 0; k < 5; k++) send_beat(100 * k, 7 - k, k == 4, 0);
        bus_idle();
        ramp_frame(1);

        // missing tlast with a 20-cycle release holdoff; 9th beat opens the next frame
        rel_delay = 20;
        for (int k = 0; k < 9; k++) send_beat(k + 3, -2 * k, 1'b0, 0);
        rel_delay = 2;
        for (int k = 1; k < N; k++) send_beat(-k, k * 11, k == N - 1, 0);
        bus_idle();

        // random frames with random lengths, gaps and release timing
        for (int f = 0; f < 24; f++) begin
            end_pos     = int'($urandom_range(8, 0));
            nbeats      = (end_pos == 8) ? N : end_pos + 1;
            rel_delay   = int'($urandom_range(4, 0));
            rel_in_done = 1'($urandom_range(1, 0));
            for (int b = 0; b < nbeats; b++) begin
                re = int'($urandom_range(65535, 0)) - 32768;
                im = int'($urandom_range(65535, 0)) - 32768;
                if ($urandom_range(3, 0) == 0) re = -32768;
                send_beat(re, im, b == end_pos, 3);
            end
            bus_idle();
        end

        // reset with k=3 accepted, then a full frame
        for (int k = 0; k < 4; k++) send_beat(k + 5, k - 9, 1'b0, 0);
        bus_idle();
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("midrst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ramp_frame(0);

        repeat (40) @(posedge clock);
        @(negedge clock);
        check_eq("writes_outstanding", wq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
